// File: rtl/dlx_mem_access_unit_pkg.sv
// dlx_mem_pkg: shared size encodings, FSM states and default SRAM depth for the DLX MEM-stage access unit.
package dlx_mem_pkg;
    localparam int MEM_WORDS_DEF = 149;
    typedef enum logic [1:0] {SZ_BYTE = 2'b00, SZ_HALF = 2'b01, SZ_WORD = 2'b10, SZ_RSVD = 2'b11} size_e;
    typedef enum logic [2:0] {ST_IDLE, ST_RD, ST_WR, ST_RMW_RD, ST_RMW_WR} state_e;
endpackage

// File: rtl/dlx_mem_access_unit_if.sv
// dlx_mem_access_unit_if: pipeline request/response handshake of the MEM-stage access unit.
interface dlx_mem_access_unit_if;
    logic        req_valid, req_ready, req_we, req_signed;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata, rsp_rdata;
    logic        rsp_valid, rsp_err;
    modport master (output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
                    input  req_ready, rsp_valid, rsp_rdata, rsp_err);
    modport slave  (input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
                    output req_ready, rsp_valid, rsp_rdata, rsp_err);
endinterface

// File: rtl/dlx_mem_lane_align.sv
// dlx_mem_lane_align: big-endian byte/half extraction with sign/zero extension, and sub-word store merge.
module dlx_mem_lane_align
    import dlx_mem_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  size_i,
    input  logic [1:0]  off_i,
    input  logic        sgn_i,
    input  logic [31:0] new_i,
    output logic [31:0] load_o,
    output logic [31:0] merge_o
);
    logic [4:0]  bsh, hsh;
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] bmask, hmask;
    always_comb begin
        // offset 0 is the most significant lane; half ignores off_i[0], giving natural alignment
        bsh = {~off_i, 3'b000};
        hsh = {~off_i[1], 4'b0000};
        b = 8'(word_i >> bsh);
        h = 16'(word_i >> hsh);
        bmask = 32'h0000_00ff << bsh;
        hmask = 32'h0000_ffff << hsh;
        load_o = size_i == SZ_BYTE ? {{24{sgn_i & b[7]}}, b}
               : size_i == SZ_HALF ? {{16{sgn_i & h[15]}}, h} : word_i;
        merge_o = size_i == SZ_BYTE ? (word_i & ~bmask) | ({24'b0, new_i[7:0]} << bsh)
                : size_i == SZ_HALF ? (word_i & ~hmask) | ({16'b0, new_i[15:0]} << hsh) : new_i;
    end
endmodule

// File: rtl/dlx_mem_access_unit.sv
// dlx_mem_access_unit: MEM-stage load/store controller driving a word SRAM, with RMW for sub-word stores.
// Define DLX_MAU_ALIGN_CHECK_EN to enable alignment/size/range error checking.
module dlx_mem_access_unit
    import dlx_mem_pkg::*;
#(
    parameter int MEM_WORDS = MEM_WORDS_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    dlx_mem_access_unit_if.slave bus,
    output logic [31:0]          mem_addr,
    inout  wire  [31:0]          mem_data,
    output logic                 mem_we,
    output logic                 mem_re
);
    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d;
    logic [1:0]  size_q, size_d;
    logic        sgn_q, sgn_d, we_q, we_d, re_q, re_d, vld_q, vld_d, err_q, err_d;
    logic [31:0] load_val, merged;
    logic        req_err;

`ifdef DLX_MAU_ALIGN_CHECK_EN
    assign req_err = (bus.req_size == SZ_HALF && bus.req_addr[0])
                  || (bus.req_size == SZ_WORD && bus.req_addr[1:0] != 2'b00)
                  || bus.req_size == SZ_RSVD
                  || {2'b00, bus.req_addr[31:2]} >= 32'(MEM_WORDS);
`else
    assign req_err = 1'b0;
`endif

    dlx_mem_lane_align u_align (
        .word_i (mem_data),
        .size_i (size_q),
        .off_i  (addr_q[1:0]),
        .sgn_i  (sgn_q),
        .new_i  (wdata_q),
        .load_o (load_val),
        .merge_o(merged)
    );

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        sgn_d   = sgn_q;
        rdata_d = 32'h0;
        we_d    = 1'b0;
        re_d    = 1'b0;
        vld_d   = 1'b0;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: if (bus.req_valid) begin
                addr_d  = bus.req_addr;
                wdata_d = bus.req_wdata;
                size_d  = bus.req_size;
                sgn_d   = bus.req_signed;
                if (req_err) begin
                    vld_d = 1'b1;
                    err_d = 1'b1;
                end else if (!bus.req_we) begin
                    state_d = ST_RD;
                    re_d    = 1'b1;
                end else if (bus.req_size == SZ_BYTE || bus.req_size == SZ_HALF) begin
                    state_d = ST_RMW_RD;
                    re_d    = 1'b1;
                end else begin
                    state_d = ST_WR;
                    we_d    = 1'b1;
                end
            end
            ST_RD: begin
                state_d = ST_IDLE;
                vld_d   = 1'b1;
                rdata_d = load_val;
            end
            ST_RMW_RD: begin
                state_d = ST_RMW_WR;
                we_d    = 1'b1;
                wdata_d = merged;
            end
            default: begin
                state_d = ST_IDLE;
                vld_d   = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            rdata_q <= 32'h0;
            size_q  <= 2'b00;
            sgn_q   <= 1'b0;
            we_q    <= 1'b0;
            re_q    <= 1'b0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            size_q  <= size_d;
            sgn_q   <= sgn_d;
            we_q    <= we_d;
            re_q    <= re_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
        end
    end

    // write enable drops with rst_n so a reset edge can never commit a write
    assign mem_we        = we_q & rst_n;
    assign mem_re        = re_q;
    assign mem_addr      = {2'b00, addr_q[31:2]};
    assign mem_data      = mem_we ? wdata_q : 'z;
    assign bus.req_ready = state_q == ST_IDLE;
    assign bus.rsp_valid = vld_q;
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
endmodule
